// File: rtl/psum_requant_drain.sv
// psum_requant_drain: two-stage valid/ready pipeline that right-shifts unsigned partial sums and
// saturates them to WIDTH bits. Optional round-half-up under macro PSUM_ROUND_NEAREST_EN.
module psum_requant_drain #(
  parameter int WIDTH      = 16,
  parameter int LOG2_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*WIDTH:0]        in_psum,
  input  logic [LOG2_WIDTH+1:0]   in_shift,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sat,
  input  logic                    sat_clr,
  output logic [15:0]             sat_count
);

  localparam int PW = 2*WIDTH + 1;
  localparam int SW = LOG2_WIDTH + 2;
  localparam logic [SW-1:0] SH_MAX = SW'(PW);
  localparam logic [PW:0]   Q_MAX  = {{(PW+1-WIDTH){1'b0}}, {WIDTH{1'b1}}};

  // Handshake: a side transfers on the rising edge where valid & ready are both high; a producer
  // holds valid and payload until that edge. in_ready depends combinationally on out_ready only.
  logic             s1_valid;
  logic             s2_valid;
  logic [PW-1:0]    s1_psum;
  logic [SW-1:0]    s1_shift;
  logic             s2_adv;

  logic [SW-1:0]    sh;
  logic [PW:0]      q;
  logic             sat_nxt;
  logic [WIDTH-1:0] data_nxt;
`ifdef PSUM_ROUND_NEAREST_EN
  logic [PW-1:0]    rnd_src;
  logic             rnd_bit;
`endif

  assign s2_adv    = s1_valid & (~s2_valid | out_ready);
  assign in_ready  = ~s1_valid | s2_adv;
  assign out_valid = s2_valid;

  always_comb begin
    sh = (s1_shift > SH_MAX) ? SH_MAX : s1_shift;
    q  = {1'b0, s1_psum} >> sh;
`ifdef PSUM_ROUND_NEAREST_EN
    // The extra top bit of q absorbs the carry so an all-ones psum never wraps to zero.
    rnd_src = '0;
    rnd_bit = 1'b0;
    if (sh != '0) begin
      rnd_src = s1_psum >> (sh - SW'(1));
      rnd_bit = rnd_src[0];
    end
    q = q + {{PW{1'b0}}, rnd_bit};
`endif
    sat_nxt  = (q > Q_MAX);
    data_nxt = sat_nxt ? {WIDTH{1'b1}} : q[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s1_psum   <= '0;
      s1_shift  <= '0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      sat_count <= 16'h0000;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_valid && in_ready) begin
        s1_psum  <= in_psum;
        s1_shift <= in_shift;
      end
      if (!s2_valid || out_ready) s2_valid <= s1_valid;
      if (s2_adv) begin
        out_data <= data_nxt;
        out_sat  <= sat_nxt;
      end
      // Clear wins over a same-cycle saturated transfer; the count sticks at all-ones.
      if (sat_clr) begin
        sat_count <= 16'h0000;
      end else if (s2_valid && out_ready && out_sat && (sat_count != 16'hFFFF)) begin
        sat_count <= sat_count + 16'h0001;
      end
    end
  end

endmodule
